video_sig_recover: RTL and testbench

//  Receive-side counterpart of video_sig_gen: takes raw hs/vs/ad timing (e.g. a captured or looped-back

---
 rtl/video_sig_recover.sv | 136 +++++++++++++
 tb/tb_video_sig_recover.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_sig_recover.sv
// video_sig_recover: rebuilds hcount/vcount, new-frame pulse and frame count from raw hs/vs/ad timing,
// checking the stream against the nominal format and reporting lock and timing errors.
module video_sig_recover #(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int H_FRONT_PORCH   = 110,
    parameter int H_SYNC_WIDTH    = 40,
    parameter int H_BACK_PORCH    = 220,
    parameter int ACTIVE_LINES    = 720,
    parameter int V_FRONT_PORCH   = 5,
    parameter int V_SYNC_WIDTH    = 5,
    parameter int V_BACK_PORCH    = 20,
    parameter int FPS             = 60,
    parameter int LOCK_FRAMES     = 2,
    localparam int TP = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH,
    localparam int TL = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH,
    localparam int HW = $clog2(TP),
    localparam int VW = $clog2(TL)
) (
    input  logic          pixel_clk_in,
    input  logic          rst_n_in,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          ad_in,
    output logic [HW-1:0] hcount_out,
    output logic [VW-1:0] vcount_out,
    output logic          ad_out,
    output logic          nf_out,
    output logic [5:0]    fc_out,
    output logic          locked_out,
    output logic          err_out
);
    localparam int TIMEOUT = 2 * TP * TL;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [HW-1:0] H_LAST = HW'(TP - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(ACTIVE_H_PIXELS);
    localparam logic [HW-1:0] H_HS   = HW'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
    localparam logic [VW-1:0] V_LAST = VW'(TL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(ACTIVE_LINES);
    localparam logic [VW-1:0] V_VS   = VW'(ACTIVE_LINES + V_FRONT_PORCH);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] G_LOCK  = GW'(LOCK_FRAMES);
    localparam logic [5:0]    FC_LAST = 6'(FPS - 1);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_q, h_d, h_e;
    logic [VW-1:0] v_q, v_d, v_e;
    logic [TW-1:0] to_q, to_d;
    logic [GW-1:0] good_q, good_d;
    logic [5:0]    fc_q, fc_d;
    logic          hs_q, vs_q, ad_q, ad_d, nf_q, nf_d, err_q, err_d;
    logic          hs_rise, vs_rise, bad;

    // (h_q, v_q) is the position of the previous sample; h_e/v_e is where the current sample should be
    assign hs_rise = hs_in & ~hs_q;
    assign vs_rise = vs_in & ~vs_q;
    assign h_e = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    assign v_e = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 1'b1;
    assign bad = (hs_rise && h_e != H_HS) || (vs_rise && (h_e != '0 || v_e != V_VS))
               || (ad_in != (h_e < H_ACT && v_e < V_ACT));

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        to_d    = to_q;
        good_d  = good_q;
        err_d   = 1'b0;
        if (state_q == SEARCH) begin
            if (vs_rise) begin
                state_d = TRACK;
                h_d     = '0;
                v_d     = V_VS;
                to_d    = '0;
                good_d  = '0;
            end
        end else begin
            h_d     = vs_rise ? '0 : hs_rise ? H_HS : h_e;
            v_d     = vs_rise ? V_VS : v_e;
            to_d    = vs_rise ? '0 : to_q + 1'b1;
            good_d  = bad ? '0 : (vs_rise && good_q != G_LOCK) ? good_q + 1'b1 : good_q;
            state_d = bad ? TRACK : (good_d == G_LOCK) ? LOCKED : state_q;
            err_d   = bad;
            // losing vs entirely drops back to search silently
            if (!vs_rise && to_q == TO_LAST) begin
                state_d = SEARCH;
                h_d     = '0;
                v_d     = '0;
                to_d    = '0;
                good_d  = '0;
                err_d   = 1'b0;
            end
        end
        ad_d = (state_d == LOCKED) && h_d < H_ACT && v_d < V_ACT;
        nf_d = (state_d == LOCKED) && h_d == H_ACT && v_d == V_ACT;
        fc_d = nf_d ? ((fc_q == FC_LAST) ? '0 : fc_q + 1'b1) : fc_q;
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= SEARCH;
            h_q     <= '0;
            v_q     <= '0;
            to_q    <= '0;
            good_q  <= '0;
            fc_q    <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            ad_q    <= 1'b0;
            nf_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            to_q    <= to_d;
            good_q  <= good_d;
            fc_q    <= fc_d;
            hs_q    <= hs_in;
            vs_q    <= vs_in;
            ad_q    <= ad_d;
            nf_q    <= nf_d;
            err_q   <= err_d;
        end
    end

    assign hcount_out = h_q;
    assign vcount_out = v_q;
    assign ad_out     = ad_q;
    assign nf_out     = nf_q;
    assign fc_out     = fc_q;
    assign locked_out = (state_q == LOCKED);
    assign err_out    = err_q;
endmodule

// File: tb/tb_video_sig_recover.sv
// tb_video_sig_recover: drives generated and perturbed video timing into video_sig_recover and checks
// every cycle against a position-based reference model, plus targeted scenario checks.
module tb_video_sig_recover;
    localparam int AH = 8, HFP = 2, HSW = 2, HBP = 4;
    localparam int AL = 6, VFP = 1, VSW = 2, VBP = 2;
    localparam int TP = AH + HFP + HSW + HBP;
    localparam int TL = AL + VFP + VSW + VBP;
    localparam int NPOS = TP * TL;
    localparam int TIMEOUT = 2 * NPOS;
    localparam int FPS = 3, LOCK = 2;
    localparam int HSH = AH + HFP;
    localparam int VSPOS = (AL + VFP) * TP;
    localparam int NFPOS = AL * TP + AH;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       hs = 1'b0, vs = 1'b0, ad = 1'b0;
    logic [3:0] hcount, vcount;
    logic       ad_o, nf_o, locked_o, err_o;
    logic [5:0] fc_o;

    int vectors = 0, miscompares = 0;

    video_sig_recover #(
        .ACTIVE_H_PIXELS(AH), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
        .ACTIVE_LINES(AL), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP),
        .FPS(FPS), .LOCK_FRAMES(LOCK)
    ) dut (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .hs_in(hs), .vs_in(vs), .ad_in(ad),
        .hcount_out(hcount), .vcount_out(vcount), .ad_out(ad_o), .nf_out(nf_o),
        .fc_out(fc_o), .locked_out(locked_o), .err_out(err_o)
    );

    always #5 clk = ~clk;

    // reference model: recovered position as a single frame offset
    int m_pos, m_good, m_tmo, m_fc;
    bit m_srch, m_lock, m_err, m_nf, m_ad, m_phs, m_pvs;

    task automatic m_reset();
        m_srch = 1; m_lock = 0; m_err = 0; m_nf = 0; m_ad = 0; m_phs = 0; m_pvs = 0;
        m_pos = 0; m_good = 0; m_tmo = 0; m_fc = 0;
    endtask

    task automatic m_step(input bit h_in, input bit v_in, input bit a_in);
        bit hr, vr, bd;
        int p, h, v;
        hr = h_in && !m_phs;
        vr = v_in && !m_pvs;
        m_phs = h_in;
        m_pvs = v_in;
        m_err = 0;
        if (m_srch) begin
            if (vr) begin
                m_srch = 0; m_pos = VSPOS; m_good = 0; m_tmo = 0;
            end
        end else begin
            p = (m_pos + 1) % NPOS;
            h = p % TP;
            v = p / TP;
            bd = (hr && h != HSH) || (vr && p != VSPOS) || (a_in != (h < AH && v < AL));
            if (vr) p = VSPOS;
            else if (hr) p = v * TP + HSH;
            m_tmo = vr ? 0 : m_tmo + 1;
            if (bd) begin
                m_err = 1; m_good = 0; m_lock = 0;
            end else if (vr) begin
                if (m_good < LOCK) m_good++;
                if (m_good == LOCK) m_lock = 1;
            end
            m_pos = p;
            if (m_tmo == TIMEOUT) begin
                m_srch = 1; m_lock = 0; m_good = 0; m_tmo = 0; m_pos = 0; m_err = 0;
            end
        end
        m_ad = m_lock && (m_pos % TP) < AH && (m_pos / TP) < AL;
        m_nf = m_lock && m_pos == NFPOS;
        if (m_nf) m_fc = (m_fc + 1) % FPS;
    endtask

    // stream generator following the same counter conventions as the transmitter
    int gh, gv, s_h, s_v;
    bit g_pvs, s_vr;

    function automatic bit g_hs();
        return gh >= HSH && gh < HSH + HSW;
    endfunction
    function automatic bit g_vs();
        return gv >= AL + VFP && gv < AL + VFP + VSW;
    endfunction
    function automatic bit g_ad();
        return gh < AH && gv < AL;
    endfunction

    task automatic tick(input bit h_in, input bit v_in, input bit a_in);
        logic [17:0] act, exp;
        hs = h_in; vs = v_in; ad = a_in;
        m_step(h_in, v_in, a_in);
        @(posedge clk);
        #1;
        act = {hcount, vcount, ad_o, nf_o, fc_o, locked_o, err_o};
        exp = {4'(m_pos % TP), 4'(m_pos / TP), m_ad, m_nf, 6'(m_fc), m_lock, m_err};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL outputs t=%0t {h,v,ad,nf,fc,lk,err} got %h/%h/%b/%b/%0d/%b/%b want %h/%h/%b/%b/%0d/%b/%b",
                     $time, act[17:14], act[13:10], act[9], act[8], act[7:2], act[1], act[0],
                     exp[17:14], exp[13:10], exp[9], exp[8], exp[7:2], exp[1], exp[0]);
        end
    endtask

    task automatic gstep(input bit fh, input bit fv, input bit fa);
        bit hv, vv, av;
        hv = g_hs() ^ fh;
        vv = g_vs() ^ fv;
        av = g_ad() ^ fa;
        s_h = gh;
        s_v = gv;
        s_vr = vv && !g_pvs;
        g_pvs = vv;
        gh = (gh + 1) % TP;
        if (gh == 0) gv = (gv + 1) % TL;
        tick(hv, vv, av);
    endtask

    task automatic seek(input int h, input int v);
        for (int n = 0; n < 2 * NPOS && !(gh == h && gv == v); n++) gstep(0, 0, 0);
    endtask

    task automatic gen_start(input int h, input int v);
        gh = h; gv = v; g_pvs = 0;
    endtask

    task automatic run_vs(input int n, output int lock_at, output int errs, output int hvb);
        int k = 0;
        lock_at = -1; errs = 0; hvb = 0;
        for (int i = 0; i < (n + 1) * NPOS && k < n; i++) begin
            gstep(0, 0, 0);
            if (s_vr) k++;
            if (err_o) errs++;
            if (locked_o && lock_at < 0) lock_at = k;
            if (k >= 1 && (hcount != 4'(s_h) || vcount != 4'(s_v))) hvb++;
        end
    endtask

    task automatic quiet_until_vs(output int nz, output bit found);
        nz = 0; found = 0;
        for (int i = 0; i < 2 * NPOS && !found; i++) begin
            gstep(0, 0, 0);
            found = s_vr;
            if (!s_vr && (hcount != 0 || vcount != 0 || locked_o || err_o || ad_o)) nz++;
        end
    endtask

    task automatic test_reset();
        hs = 0; vs = 0; ad = 0;
        #2 rst_n = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({hcount, vcount, ad_o, nf_o, fc_o, locked_o, err_o} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_state got %h want 0", {hcount, vcount, ad_o, nf_o, fc_o, locked_o, err_o});
        end
        #2 rst_n = 1;
    endtask

    task automatic test_clean_lock();
        int lock_at, errs, hvb;
        gen_start($urandom_range(0, TP - 1), $urandom_range(0, AL + VFP - 1));
        run_vs(4, lock_at, errs, hvb);
        vectors += 3;
        if (lock_at != 3) begin miscompares++; $display("FAIL clean_lock_vs got %0d want 3", lock_at); end
        if (errs != 0) begin miscompares++; $display("FAIL clean_errs got %0d want 0", errs); end
        if (hvb != 0) begin miscompares++; $display("FAIL clean_hv_track got %0d bad want 0", hvb); end
    endtask

    task automatic test_late_hs();
        int lock_at, errs, hvb, line;
        line = $urandom_range(0, TL - 1);
        vectors++;
        if (locked_o !== 1'b1) begin miscompares++; $display("FAIL late_pre_lock got %b want 1", locked_o); end
        seek(HSH - 1, line);
        repeat (3) tick(g_hs(), g_vs(), g_ad());
        gstep(0, 0, 0);
        gstep(0, 0, 0);
        vectors++;
        if ({err_o, locked_o, hcount, vcount} !== {1'b1, 1'b0, 4'(HSH), 4'(line)}) begin
            miscompares++;
            $display("FAIL late_edge {err,lk,h,v} got %b/%b/%0d/%0d want 1/0/%0d/%0d",
                     err_o, locked_o, hcount, vcount, HSH, line);
        end
        run_vs(3, lock_at, errs, hvb);
        vectors += 3;
        if (lock_at != 2) begin miscompares++; $display("FAIL late_relock_vs got %0d want 2", lock_at); end
        if (errs != 0) begin miscompares++; $display("FAIL late_extra_errs got %0d want 0", errs); end
        if (hvb != 0) begin miscompares++; $display("FAIL late_hv_track got %0d bad want 0", hvb); end
    endtask

    task automatic test_ad_glitch();
        int lock_at, errs, hvb;
        seek($urandom_range(0, AH - 1), $urandom_range(0, AL - 1));
        gstep(0, 0, 1);
        vectors++;
        if ({err_o, locked_o, ad_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL glitch_edge {err,lk,ad} got %b%b%b want 100", err_o, locked_o, ad_o);
        end
        gstep(0, 0, 0);
        vectors++;
        if (ad_o !== 1'b0) begin miscompares++; $display("FAIL glitch_ad_next got %b want 0", ad_o); end
        run_vs(3, lock_at, errs, hvb);
        vectors++;
        if (lock_at != 2) begin miscompares++; $display("FAIL glitch_relock_vs got %0d want 2", lock_at); end
    endtask

    task automatic test_timeout();
        int nz;
        bit found;
        vectors++;
        if (locked_o !== 1'b1) begin miscompares++; $display("FAIL timeout_pre_lock got %b want 1", locked_o); end
        repeat (TIMEOUT + 8) tick(0, 0, 0);
        vectors++;
        if ({hcount, vcount, ad_o, nf_o, locked_o, err_o} !== 12'd0) begin
            miscompares++;
            $display("FAIL timeout_search got %h want 0", {hcount, vcount, ad_o, nf_o, locked_o, err_o});
        end
        gen_start($urandom_range(0, TP - 1), $urandom_range(0, AL + VFP - 1));
        quiet_until_vs(nz, found);
        vectors += 2;
        if (nz != 0 || !found) begin
            miscompares++;
            $display("FAIL timeout_quiet got %0d active found=%b want 0/1", nz, found);
        end
        if ({hcount, vcount} !== {4'd0, 4'(AL + VFP)}) begin
            miscompares++;
            $display("FAIL timeout_reacquire got %0d/%0d want 0/%0d", hcount, vcount, AL + VFP);
        end
    endtask

    task automatic test_frame_count();
        int lock_at, errs, hvb, got, posbad, dbl;
        int want[4] = '{1, 2, 0, 1};
        int vals[4];
        bit pnf;
        test_reset();
        gen_start(0, 0);
        run_vs(3, lock_at, errs, hvb);
        got = 0; posbad = 0; dbl = 0; pnf = 0;
        for (int i = 0; i < 6 * NPOS && got < 4; i++) begin
            gstep(0, 0, 0);
            if (nf_o) begin
                vals[got] = int'(fc_o);
                got++;
                if (hcount != 4'(AH) || vcount != 4'(AL)) posbad++;
                if (pnf) dbl++;
            end
            pnf = nf_o;
        end
        vectors += 3;
        if (got != 4) begin miscompares++; $display("FAIL nf_count got %0d want 4", got); end
        if (posbad != 0) begin miscompares++; $display("FAIL nf_position got %0d bad want 0", posbad); end
        if (dbl != 0) begin miscompares++; $display("FAIL nf_width got %0d long want 0", dbl); end
        for (int i = 0; i < got; i++) begin
            vectors++;
            if (vals[i] != want[i]) begin
                miscompares++;
                $display("FAIL fc_seq[%0d] got %0d want %0d", i, vals[i], want[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        int nz;
        bit found;
        seek($urandom_range(0, TP - 1), $urandom_range(0, AL - 2));
        #3 rst_n = 0;
        #1;
        m_reset();
        vectors++;
        if ({hcount, vcount, ad_o, nf_o, fc_o, locked_o, err_o} !== 18'd0) begin
            miscompares++;
            $display("FAIL async_reset got %h want 0", {hcount, vcount, ad_o, nf_o, fc_o, locked_o, err_o});
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        quiet_until_vs(nz, found);
        vectors++;
        if (nz != 0 || !found) begin
            miscompares++;
            $display("FAIL async_quiet got %0d active found=%b want 0/1", nz, found);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5 * NPOS; i++)
            gstep($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0);
    endtask

    initial begin
        m_reset();
        test_reset();
        test_clean_lock();
        test_late_hs();
        test_ad_glitch();
        test_timeout();
        test_frame_count();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
